// File: rtl/bg_lsu_arb_xbar.sv
// Per-LSU write queues arbitrated round-robin onto NUM_CH bank groups.
// Reads take priority over writes and return data on a fixed two-cycle path.
module bg_lsu_arb_xbar #(
  parameter int NUM_CH   = 4,
  parameter int SEL_W    = 2,
  parameter int A_W      = 10,
  parameter int D_W      = 32,
  parameter int WQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ren_i,
  input  logic [NUM_CH*A_W-1:0]   raddr_i,
  input  logic [NUM_CH-1:0]       wvalid_i,
  output logic [NUM_CH-1:0]       wready_o,
  input  logic [NUM_CH*SEL_W-1:0] wsel_i,
  input  logic [NUM_CH*A_W-1:0]   waddr_i,
  input  logic [NUM_CH*D_W-1:0]   wdata_i,
  output logic [NUM_CH-1:0]       bg_ren_o,
  output logic [NUM_CH-1:0]       bg_wen_o,
  output logic [NUM_CH*A_W-1:0]   bg_addr_o,
  output logic [NUM_CH*D_W-1:0]   bg_wdata_o,
  input  logic [NUM_CH*D_W-1:0]   bg_rdata_i,
  output logic [NUM_CH-1:0]       lsu_rvalid_o,
  output logic [NUM_CH*D_W-1:0]   lsu_rdata_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);
  localparam int PTR_W   = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CNT_Q_W = PTR_W + 1;

  logic [NUM_CH-1:0]             push;
  logic [NUM_CH-1:0]             pop;
  logic [NUM_CH-1:0]             q_valid;
  logic [NUM_CH-1:0][SEL_W-1:0]  head_sel;
  logic [NUM_CH-1:0][A_W-1:0]    head_addr;
  logic [NUM_CH-1:0][D_W-1:0]    head_data;
  logic [NUM_CH-1:0][NUM_CH-1:0] gnt_mat;    // [bank][lsu]
  logic [NUM_CH-1:0]             stall_bank;

  logic [NUM_CH-1:0]             bg_ren_d, bg_ren_q;
  logic [NUM_CH-1:0]             bg_wen_d, bg_wen_q;
  logic [NUM_CH-1:0][A_W-1:0]    bg_addr_d, bg_addr_q;
  logic [NUM_CH-1:0][D_W-1:0]    bg_wdata_d, bg_wdata_q;
  logic [NUM_CH-1:0]             rvalid_d, rvalid_q;
  logic [CNT_W-1:0]              stall_cnt_d, stall_cnt_q;
  // High for the first cycle after reset release so no bank command issues then.
  logic                          blk_d, blk_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_wq
      logic [SEL_W-1:0]   sel_mem  [WQ_DEPTH];
      logic [A_W-1:0]     addr_mem [WQ_DEPTH];
      logic [D_W-1:0]     data_mem [WQ_DEPTH];
      logic [PTR_W-1:0]   wr_ptr_d, wr_ptr_q;
      logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q;
      logic [CNT_Q_W-1:0] count_d, count_q;

      assign wready_o[gi]  = (count_q != CNT_Q_W'(WQ_DEPTH));
      assign push[gi]      = wvalid_i[gi] && (count_q != CNT_Q_W'(WQ_DEPTH));
      assign q_valid[gi]   = (count_q != '0);
      assign head_sel[gi]  = sel_mem[rd_ptr_q];
      assign head_addr[gi] = addr_mem[rd_ptr_q];
      assign head_data[gi] = data_mem[rd_ptr_q];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push[gi] && !pop[gi])      count_d = count_q + CNT_Q_W'(1);
        else if (!push[gi] && pop[gi]) count_d = count_q - CNT_Q_W'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Payload storage needs no reset: count_q alone decides what is valid.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          sel_mem[wr_ptr_q]  <= wsel_i[gi*SEL_W +: SEL_W];
          addr_mem[wr_ptr_q] <= waddr_i[gi*A_W +: A_W];
          data_mem[wr_ptr_q] <= wdata_i[gi*D_W +: D_W];
        end
      end
    end

    for (gi = 0; gi < NUM_CH; gi++) begin : g_bank
      logic [SEL_W-1:0]  rr_d, rr_q;
      logic [NUM_CH-1:0] cand;
      logic [NUM_CH-1:0] gnt;
      logic [SEL_W-1:0]  gidx;
      logic [SEL_W-1:0]  idx;
      logic              found;
      logic              rd_en;
      logic              wen;

      assign rd_en = ren_i[gi] && !blk_q;

      always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          cand[k] = q_valid[k] && (head_sel[k] == SEL_W'(gi));
        end
      end

      // First candidate at or after rr_q wins; a read on this bank vetoes it.
      always_comb begin
        gnt   = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
          idx = rr_q + SEL_W'(off);
          if (!found && cand[idx]) begin
            found = 1'b1;
            gidx  = idx;
          end
        end
        if (found && !rd_en && !blk_q) gnt[gidx] = 1'b1;
        rr_d = (gnt != '0) ? gidx + SEL_W'(1) : rr_q;
      end

      assign wen              = (gnt != '0);
      assign gnt_mat[gi]      = gnt;
      assign stall_bank[gi]   = ((cand & ~gnt) != '0);
      assign bg_ren_d[gi]     = rd_en;
      assign bg_wen_d[gi]     = wen;
      assign bg_addr_d[gi]    = rd_en ? raddr_i[gi*A_W +: A_W] :
                                (wen ? head_addr[gidx] : '0);
      assign bg_wdata_d[gi]   = wen ? head_data[gidx] : '0;
      assign lsu_rdata_o[gi*D_W +: D_W] = rvalid_q[gi] ? bg_rdata_i[gi*D_W +: D_W] : '0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
      end
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int b = 0; b < NUM_CH; b++) begin
      pop = pop | gnt_mat[b];
    end
  end

  assign rvalid_d    = bg_ren_q;
  assign blk_d       = 1'b0;
  assign stall_cnt_d = ((stall_bank != '0) && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_ren_q    <= '0;
      bg_wen_q    <= '0;
      bg_addr_q   <= '0;
      bg_wdata_q  <= '0;
      rvalid_q    <= '0;
      stall_cnt_q <= '0;
      blk_q       <= 1'b1;
    end else begin
      bg_ren_q    <= bg_ren_d;
      bg_wen_q    <= bg_wen_d;
      bg_addr_q   <= bg_addr_d;
      bg_wdata_q  <= bg_wdata_d;
      rvalid_q    <= rvalid_d;
      stall_cnt_q <= stall_cnt_d;
      blk_q       <= blk_d;
    end
  end

  assign bg_ren_o     = bg_ren_q;
  assign bg_wen_o     = bg_wen_q;
  assign bg_addr_o    = bg_addr_q;
  assign bg_wdata_o   = bg_wdata_q;
  assign lsu_rvalid_o = rvalid_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_bg_lsu_arb_xbar.sv
// Scoreboard bench for bg_lsu_arb_xbar: a queue-based reference model predicts
// every bank command, read return, wready and stall count; a monitor compares.
module tb_bg_lsu_arb_xbar;
  localparam int NUM_CH   = 4;
  localparam int SEL_W    = 2;
  localparam int A_W      = 10;
  localparam int D_W      = 32;
  localparam int WQ_DEPTH = 4;
  localparam int CNT_W    = 4;   // small so saturation is reachable
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       ren;
  logic [NUM_CH*A_W-1:0]   raddr;
  logic [NUM_CH-1:0]       wvalid;
  logic [NUM_CH-1:0]       wready_o;
  logic [NUM_CH*SEL_W-1:0] wsel;
  logic [NUM_CH*A_W-1:0]   waddr;
  logic [NUM_CH*D_W-1:0]   wdata;
  logic [NUM_CH-1:0]       bg_ren_o;
  logic [NUM_CH-1:0]       bg_wen_o;
  logic [NUM_CH*A_W-1:0]   bg_addr_o;
  logic [NUM_CH*D_W-1:0]   bg_wdata_o;
  logic [NUM_CH*D_W-1:0]   bg_rdata;
  logic [NUM_CH-1:0]       lsu_rvalid_o;
  logic [NUM_CH*D_W-1:0]   lsu_rdata_o;
  logic [CNT_W-1:0]        stall_cnt_o;

  bg_lsu_arb_xbar #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .A_W(A_W), .D_W(D_W),
    .WQ_DEPTH(WQ_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ren_i(ren), .raddr_i(raddr),
    .wvalid_i(wvalid), .wready_o(wready_o),
    .wsel_i(wsel), .waddr_i(waddr), .wdata_i(wdata),
    .bg_ren_o(bg_ren_o), .bg_wen_o(bg_wen_o),
    .bg_addr_o(bg_addr_o), .bg_wdata_o(bg_wdata_o),
    .bg_rdata_i(bg_rdata),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [A_W-1:0]   addr;
    logic [D_W-1:0]   data;
  } wr_t;

  typedef struct packed {
    int             cyc;
    logic           is_rd;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } cmd_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_seen = 0;
  logic force_on = 1'b0;
  logic [D_W-1:0] force_val = '0;

  wr_t  mq [NUM_CH][$];   // model write queues
  cmd_t eq [NUM_CH][$];   // expected bank commands
  int   rq [NUM_CH][$];   // expected read-return cycles
  int   rr_m [NUM_CH];
  int   stall_m = 0;
  bit   blk_m = 1'b1;
  logic [NUM_CH-1:0] wready_m = '1;
  logic [A_W-1:0] b3_log [$];

  function automatic logic [D_W-1:0] rd_pat(input int c, input int b);
    logic [31:0] v;
    v = 32'(c) * 32'h9E37_79B1 + 32'(b) * 32'h0100_0193 + 32'h0000_1234;
    return D_W'(v);
  endfunction

  always_comb begin
    for (int b = 0; b < NUM_CH; b++) bg_rdata[b*D_W +: D_W] = rd_pat(cyc, b);
    if (force_on) bg_rdata[3*D_W +: D_W] = force_val;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: advances once per rising edge from the inputs it sampled.
  always @(posedge clk) begin : model
    logic [NUM_CH-1:0] pop_m;
    bit   any_stall;
    bit   room;
    int   ncand;
    int   k;
    wr_t  w;
    cmd_t c;
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mq[i].delete();
        rr_m[i] = 0;
      end
      stall_m  = 0;
      blk_m    = 1'b1;
      wready_m = '1;
    end else begin
      pop_m = '0;
      any_stall = 1'b0;
      for (int b = 0; b < NUM_CH; b++) begin
        ncand = 0;
        for (int j = 0; j < NUM_CH; j++)
          if (mq[j].size() > 0 && int'(mq[j][0].sel) == b) ncand++;
        if (!blk_m && ren[b]) begin
          c.cyc = cyc; c.is_rd = 1'b1; c.addr = raddr[b*A_W +: A_W]; c.data = '0;
          eq[b].push_back(c);
          rq[b].push_back(cyc + 1);
          if (ncand > 0) any_stall = 1'b1;
        end else if (!blk_m && ncand > 0) begin
          k = rr_m[b];
          for (int j = 0; j < NUM_CH; j++) begin
            k = (rr_m[b] + j) % NUM_CH;
            if (mq[k].size() > 0 && int'(mq[k][0].sel) == b) break;
          end
          w = mq[k][0];
          c.cyc = cyc; c.is_rd = 1'b0; c.addr = w.addr; c.data = w.data;
          eq[b].push_back(c);
          pop_m[k] = 1'b1;
          rr_m[b] = (k + 1) % NUM_CH;
          if (ncand > 1) any_stall = 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        room = (mq[i].size() < WQ_DEPTH);
        if (pop_m[i]) w = mq[i].pop_front();
        if (wvalid[i] && room) begin
          w.sel = wsel[i*SEL_W +: SEL_W]; w.addr = waddr[i*A_W +: A_W]; w.data = wdata[i*D_W +: D_W];
          mq[i].push_back(w);
        end
        wready_m[i] = (mq[i].size() < WQ_DEPTH);
      end
      if (any_stall && stall_m < STALL_MAX) stall_m++;
      blk_m = 1'b0;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin : monitor
    cmd_t e;
    bit   ev;
    logic [D_W-1:0] rexp;
    if (rst) begin
      for (int b = 0; b < NUM_CH; b++) begin
        eq[b].delete();
        rq[b].delete();
      end
      check("rst_outputs_zero", 64'(|{bg_ren_o, bg_wen_o, bg_addr_o, bg_wdata_o,
                                     lsu_rvalid_o, lsu_rdata_o, stall_cnt_o}), 64'd0);
      check("rst_wready", 64'(wready_o), 64'(4'hF));
    end else begin
      for (int b = 0; b < NUM_CH; b++) begin
        e = '0;
        if (eq[b].size() > 0 && eq[b][0].cyc == cyc) e = eq[b].pop_front();
        ev = (e.cyc == cyc) && (cyc != 0);
        if (bg_ren_o[b] || bg_wen_o[b])
          $display("cyc=%0d bank=%0d %s addr=%h data=%h", cyc, b, bg_ren_o[b] ? "rd" : "wr",
                   bg_addr_o[b*A_W +: A_W], bg_wdata_o[b*D_W +: D_W]);
        if (bg_wen_o[b]) wr_seen++;
        if (b == 3 && bg_wen_o[b]) b3_log.push_back(bg_addr_o[b*A_W +: A_W]);
        check($sformatf("bank%0d_cmd", b),
              64'({bg_ren_o[b], bg_wen_o[b], bg_addr_o[b*A_W +: A_W], bg_wdata_o[b*D_W +: D_W]}),
              64'({ev && e.is_rd, ev && !e.is_rd, ev ? e.addr : A_W'(0), ev ? e.data : D_W'(0)}));
        ev = (rq[b].size() > 0 && rq[b][0] == cyc);
        if (ev) void'(rq[b].pop_front());
        rexp = ev ? bg_rdata[b*D_W +: D_W] : '0;
        check($sformatf("lsu%0d_rd", b),
              64'({lsu_rvalid_o[b], lsu_rdata_o[b*D_W +: D_W]}), 64'({ev, rexp}));
      end
      check("wready", 64'(wready_o), 64'(wready_m));
      check("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ren = '0; wvalid = '0;
  endtask

  task automatic set_wr(input int l, input int s, input int a, input logic [D_W-1:0] d);
    wvalid[l] = 1'b1;
    wsel[l*SEL_W +: SEL_W] = SEL_W'(s);
    waddr[l*A_W +: A_W] = A_W'(a);
    wdata[l*D_W +: D_W] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
  endtask

  bit acc;

  initial begin
    rst = 1'b1;
    ren = '0; raddr = '0; wvalid = '0; wsel = '0; waddr = '0; wdata = '0;
    repeat (3) step();
    check("init_bg_cmd", 64'(|{bg_ren_o, bg_wen_o, bg_addr_o, bg_wdata_o}), 64'd0);
    check("init_rvalid", 64'(lsu_rvalid_o), 64'd0);
    check("init_stall", 64'(stall_cnt_o), 64'd0);
    check("init_wready", 64'(wready_o), 64'(4'hF));
    rst = 1'b0;
    step(); step();

    // Single write LSU2 -> bank 1, visible two cycles later for one cycle.
    set_wr(2, 1, 10'h005, 32'hDEADBEEF);
    step();
    idle_inputs();
    step();
    check("single_wen", 64'(bg_wen_o[1]), 64'd1);
    check("single_addr", 64'(bg_addr_o[1*A_W +: A_W]), 64'h005);
    check("single_data", 64'(bg_wdata_o[1*D_W +: D_W]), 64'hDEADBEEF);
    step();
    check("single_one_cycle", 64'(bg_wen_o[1]), 64'd0);

    // Read path on bank 3.
    ren[3] = 1'b1; raddr[3*A_W +: A_W] = 10'h3FF;
    step();
    ren = '0;
    check("read_ren", 64'(bg_ren_o[3]), 64'd1);
    check("read_addr", 64'(bg_addr_o[3*A_W +: A_W]), 64'h3FF);
    step();
    force_val = 32'h12345678; force_on = 1'b1;
    #1;
    check("read_rvalid", 64'(lsu_rvalid_o[3]), 64'd1);
    check("read_rdata", 64'(lsu_rdata_o[3*D_W +: D_W]), 64'h12345678);
    step();
    force_on = 1'b0;
    step();

    // All four LSUs hammer bank 3 three times: grants rotate 0,1,2,3,...
    do_reset();
    b3_log.delete();
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < NUM_CH; l++) set_wr(l, 3, l * 16 + r, 32'(l * 256 + r));
      step();
    end
    idle_inputs();
    repeat (16) step();
    check("conflict_count", 64'(b3_log.size()), 64'd12);
    for (int n = 0; n < 12 && n < b3_log.size(); n++)
      check($sformatf("conflict_order%0d", n), 64'(b3_log[n]), 64'((n % 4) * 16 + n / 4));

    // Read priority: three read cycles hold off LSU1's write to bank 0.
    do_reset();
    set_wr(1, 0, 10'h011, 32'hCAFE0001);
    step();
    idle_inputs();
    ren[0] = 1'b1; raddr[0 +: A_W] = 10'h020;
    repeat (3) step();
    ren = '0;
    repeat (3) step();
    check("rdprio_stall", 64'(stall_cnt_o), 64'd3);

    // Full queue: bank 0 read-blocked, LSU0 pushes WQ_DEPTH+1 writes.
    do_reset();
    ren[0] = 1'b1;
    for (int n = 0; n < WQ_DEPTH; n++) begin
      set_wr(0, 0, 10'h100 + n, 32'(n));
      check($sformatf("full_ready%0d", n), 64'(wready_o[0]), 64'd1);
      step();
    end
    set_wr(0, 0, 10'h1FF, 32'h5555AAAA);
    check("full_not_ready", 64'(wready_o[0]), 64'd0);
    step(); step();
    check("full_still_blocked", 64'(wready_o[0]), 64'd0);
    ren = '0;
    acc = 1'b0;
    for (int n = 0; n < 10; n++) begin
      acc = wready_o[0];
      step();
      if (acc) break;
    end
    wvalid = '0;
    check("fifth_accepted", 64'(acc), 64'd1);
    repeat (8) step();

    // Reset mid-burst with three queued writes behind a read-blocked bank.
    ren[2] = 1'b1; raddr[2*A_W +: A_W] = 10'h0AA;
    for (int n = 0; n < 3; n++) begin
      set_wr(1, 2, 10'h200 + n, 32'hB000_0000 + 32'(n));
      step();
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    check("midrst_zero", 64'(|{bg_ren_o, bg_wen_o, bg_addr_o, bg_wdata_o,
                                lsu_rvalid_o, lsu_rdata_o, stall_cnt_o}), 64'd0);
    check("midrst_wready", 64'(wready_o), 64'(4'hF));
    step(); step();
    rst = 1'b0;
    wr_seen = 0;
    repeat (10) step();
    check("midrst_no_stale_write", 64'(wr_seen), 64'd0);

    // Randomized traffic checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NUM_CH; b++) begin
        ren[b] = ($urandom_range(0, 3) == 0);
        raddr[b*A_W +: A_W] = A_W'($urandom);
        wvalid[b] = ($urandom_range(0, 1) == 1);
        wsel[b*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, NUM_CH - 1));
        waddr[b*A_W +: A_W] = A_W'($urandom);
        wdata[b*D_W +: D_W] = D_W'($urandom);
      end
      step();
    end
    idle_inputs();
    repeat (30) step();
    check("drained_wready", 64'(wready_o), 64'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_lsu_arb_xbar.md
BG_LSU_ARB_XBAR -- requirements
Module: bg_lsu_arb_xbar

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CH, 4, number of LSU ports and bank groups (power of 2, 2..16)
- SEL_W, 2, log2(NUM_CH), bank-group select width
- A_W, 10, bank address width
- D_W, 32, data width
- WQ_DEPTH, 4, per-LSU write-queue entries (power of 2, >=2)
- CNT_W, 16, stall counter width

REQ-002 Ports SHALL be, one per line (per-channel buses flattened, channel i at slice i):
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ren_i  in  NUM_CH  read enable, LSU i reads bank group i
- raddr_i  in  NUM_CH*A_W  read address
- wvalid_i  in  NUM_CH  write request valid
- wready_o  out  NUM_CH  write queue not full
- wsel_i  in  NUM_CH*SEL_W  target bank group of write
- waddr_i  in  NUM_CH*A_W  write address
- wdata_i  in  NUM_CH*D_W  write data
- bg_ren_o  out  NUM_CH  bank read enable (registered)
- bg_wen_o  out  NUM_CH  bank write enable (registered)
- bg_addr_o  out  NUM_CH*A_W  bank address (registered)
- bg_wdata_o  out  NUM_CH*D_W  bank write data (registered)
- bg_rdata_i  in  NUM_CH*D_W  bank read data, valid one cycle after bg_ren_o
- lsu_rvalid_o  out  NUM_CH  read data valid to LSU i
- lsu_rdata_o  out  NUM_CH*D_W  read data to LSU i
- stall_cnt_o  out  CNT_W  saturating count of write-stall cycles

Function
REQ-003 Each LSU i SHALL own a FIFO of WQ_DEPTH entries {wsel, waddr, wdata}; push on wvalid_i[i] && wready_o[i].
REQ-004 wready_o[i] SHALL equal !full of queue i, from registered state only; no push on full, no same-cycle bypass.
REQ-005 A queue head is a candidate for bank group b when the queue is non-empty and head wsel == b.
REQ-006 Reads SHALL take priority: if ren_i[b]=1, no write is granted to bank b that cycle.
REQ-007 Otherwise bank b SHALL grant exactly one candidate by round-robin, starting search at rr_ptr[b]; the granted queue pops that cycle.
REQ-008 After a grant to channel k, rr_ptr[b] SHALL become (k+1) mod NUM_CH; with no grant it holds.
REQ-009 A queue head targets only one bank, so at most one pop per queue per cycle.
REQ-010 Each cycle, bank b output registers SHALL load:
- read: bg_ren_o=1, bg_wen_o=0, bg_addr_o=raddr_i[b], bg_wdata_o=0
- granted write: bg_wen_o=1, bg_ren_o=0, bg_addr_o=head waddr, bg_wdata_o=head wdata
- idle: all fields 0
REQ-011 Latency: write accepted at edge t SHALL reach bg_wen_o no earlier than cycle t+2 (empty queue, no conflict).
REQ-012 Latency: ren_i at cycle t SHALL produce bg_ren_o at t+1, and lsu_rvalid_o[i]=1 at t+2 with lsu_rdata_o[i]=bg_rdata_i[i] combinationally in that cycle.
REQ-013 lsu_rdata_o[i] SHALL be 0 when lsu_rvalid_o[i]=0.
REQ-014 A simultaneous push and pop on one queue SHALL leave its count unchanged; pointers wrap modulo WQ_DEPTH.
REQ-015 stall_cnt_o SHALL increment by 1 in any cycle where at least one candidate exists but is not granted (read-blocked or lost arbitration), and SHALL saturate at all-ones.
REQ-016 Write order per LSU SHALL be preserved; a blocked head blocks its own queue only.

Reset
REQ-017 While rst=1, all queues SHALL be empty, all rr_ptr=0, stall_cnt_o=0, bg_* outputs=0, lsu_rvalid_o=0, lsu_rdata_o=0 and wready_o=all ones.
REQ-018 Assertion of rst mid-operation SHALL discard queued writes and any in-flight read valid immediately; no bank command issues in the first cycle after deassertion.

Verification
REQ-019 Single write: LSU2 wsel=1, addr=0x05, data=0xDEADBEEF at t -> bg_wen_o[1]=1, bg_addr_o[1]=0x05, bg_wdata_o[1]=0xDEADBEEF at t+2, one cycle only.
REQ-020 Conflict: LSU0..3 all write bank 3 in the same cycle, repeated 3x -> bank 3 grants in order 0,1,2,3,0,1,... one per cycle; stall_cnt_o advances each cycle in which a candidate waits.
REQ-021 Read priority: ren_i[0]=1 for 3 cycles while LSU1 writes bank 0 -> bg_ren_o[0] for 3 cycles, then write issues; stall_cnt_o=3.
REQ-022 Full: LSU0 targets a permanently read-blocked bank and pushes WQ_DEPTH+1 writes -> wready_o[0]=0 after WQ_DEPTH accepts; 5th write accepted only after first pop.
REQ-023 Read path: ren_i[3]=1, raddr=0x3FF, bg_rdata_i[3]=0x12345678 at t+2 -> lsu_rvalid_o[3]=1, lsu_rdata_o[3]=0x12345678 at t+2.
REQ-024 Reset mid-burst: rst asserted with 3 queued writes -> all outputs 0 and wready_o=all ones immediately; no queued write ever appears after release.
